// File: rtl/fwd_pkg.sv
// Shared types for the EX-stage forwarding and load-use hazard controller.
package fwd_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10,
    FWD_ZERO  = 2'b11
  } fwd_sel_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             mem_read;
  } ex_info_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
  } mem_info_t;

  // A pipeline slot can only be a forwarding source if it really writes a non-XZR register.
  function automatic logic is_producer(input logic valid, input logic reg_write,
                                       input logic [REG_W-1:0] rd,
                                       input logic [REG_W-1:0] src,
                                       input logic [REG_W-1:0] zero_idx);
    return valid && reg_write && (rd == src) && (rd != zero_idx);
  endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// Select logic for one EX operand: picks the mux source and flags a pending-load hit.
module fwd_operand_sel
  import fwd_pkg::*;
#(
  parameter logic [REG_W-1:0] ZERO_IDX = ZERO_REG
) (
  input  logic [REG_W-1:0] src_i,
  input  logic             use_i,
  input  logic             valid_i,
  input  ex_info_t         ex_i,
  input  mem_info_t        mem_i,
  output fwd_sel_t         sel_o,
  output logic             load_hit_o
);

  logic ex_hit_s;
  logic mem_hit_s;

  assign ex_hit_s  = is_producer(ex_i.valid, ex_i.reg_write, ex_i.rd, src_i, ZERO_IDX);
  assign mem_hit_s = is_producer(mem_i.valid, mem_i.reg_write, mem_i.rd, src_i, ZERO_IDX);

  // The younger EX producer wins over MEM; XZR always reads zero.
  always_comb begin
    sel_o = FWD_RF;
    if (!(valid_i && use_i)) begin
      sel_o = FWD_RF;
    end else if (src_i == ZERO_IDX) begin
      sel_o = FWD_ZERO;
    end else if (ex_hit_s) begin
      sel_o = FWD_EXMEM;
    end else if (mem_hit_s) begin
      sel_o = FWD_MEMWB;
    end else begin
      sel_o = FWD_RF;
    end
  end

  // A load in EX cannot forward yet, regardless of its reg_write flag.
  always_comb begin
    load_hit_o = 1'b0;
    if (use_i && ex_i.valid && ex_i.mem_read && (ex_i.rd == src_i) && (ex_i.rd != ZERO_IDX)) begin
      load_hit_o = 1'b1;
    end else begin
      load_hit_o = 1'b0;
    end
  end

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding / load-use hazard controller: shadows EX and MEM destinations,
// registers the operand mux selects and counts load-use stall cycles.
module forward_ctrl
  import fwd_pkg::fwd_sel_t, fwd_pkg::ex_info_t, fwd_pkg::mem_info_t,
         fwd_pkg::FWD_RF;
#(
  parameter int               REG_W    = 5,
  parameter logic [REG_W-1:0] ZERO_REG = 5'd31,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rn,
  input  logic [REG_W-1:0] id_rm,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             hold,
  input  logic             flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  ex_info_t         ex_q,    ex_d;
  mem_info_t        mem_q,   mem_d;
  fwd_sel_t         fwd_a_q, fwd_a_d;
  fwd_sel_t         fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  fwd_sel_t sel_a_s;
  fwd_sel_t sel_b_s;
  logic     hit_a_s;
  logic     hit_b_s;
  logic     stall_s;

  fwd_operand_sel #(.ZERO_IDX(ZERO_REG)) u_sel_rn (
    .src_i      (id_rn),
    .use_i      (id_use_rn),
    .valid_i    (id_valid),
    .ex_i       (ex_q),
    .mem_i      (mem_q),
    .sel_o      (sel_a_s),
    .load_hit_o (hit_a_s)
  );

  fwd_operand_sel #(.ZERO_IDX(ZERO_REG)) u_sel_rm (
    .src_i      (id_rm),
    .use_i      (id_use_rm),
    .valid_i    (id_valid),
    .ex_i       (ex_q),
    .mem_i      (mem_q),
    .sel_o      (sel_b_s),
    .load_hit_o (hit_b_s)
  );

  assign stall_s = reset && id_valid && !flush && (hit_a_s || hit_b_s);

  // Pipeline shadow update: flush beats hold, hold beats the load-use bubble.
  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    cnt_d   = cnt_q;
    if (flush) begin
      ex_d.valid  = 1'b0;
      mem_d.valid = 1'b0;
      fwd_a_d     = FWD_RF;
      fwd_b_d     = FWD_RF;
    end else if (hold) begin
      cnt_d = cnt_q;
    end else if (stall_s) begin
      mem_d    = '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
      ex_d.valid = 1'b0;
      fwd_a_d  = FWD_RF;
      fwd_b_d  = FWD_RF;
      cnt_d    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      mem_d   = '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
      ex_d    = '{valid: id_valid, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
      fwd_a_d = sel_a_s;
      fwd_b_d = sel_b_s;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_a_sel   = fwd_a_q;
  assign fwd_b_sel   = fwd_b_q;
  assign stall       = stall_s;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_forward_ctrl.sv
// Randomized and directed bench for forward_ctrl against a slot-list reference model.
module tb_forward_ctrl;

  localparam int TB_CNT_W = 8;
  localparam int CMAX     = (1 << TB_CNT_W) - 1;
  localparam int XZR      = 31;

  logic                clk = 1'b0;
  logic                reset;
  logic                id_valid, id_use_rn, id_use_rm, id_reg_write, id_mem_read;
  logic [4:0]          id_rn, id_rm, id_rd;
  logic                hold, flush;
  logic [1:0]          fwd_a_sel, fwd_b_sel;
  logic                stall;
  logic [TB_CNT_W-1:0] stall_count;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    bit v;
    int rd;
    bit wr;
    bit ld;
  } slot_t;

  // pipe[0] is the instruction in EX, pipe[1] the one in MEM
  slot_t pipe [2];
  int    m_a, m_b, m_cnt;

  forward_ctrl #(.CNT_W(TB_CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rn        (id_rn),
    .id_rm        (id_rm),
    .id_use_rn    (id_use_rn),
    .id_use_rm    (id_use_rm),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .hold         (hold),
    .flush        (flush),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall        (stall),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Youngest in-flight writer of src wins; slot index k maps to select k+1.
  function automatic int exp_sel(input bit use_op, input int src);
    if (!id_valid || !use_op) return 0;
    if (src == XZR) return 3;
    for (int k = 0; k < 2; k++)
      if (pipe[k].v && pipe[k].wr && pipe[k].rd == src) return k + 1;
    return 0;
  endfunction

  task automatic cycle();
    bit es;
    int na, nb;
    #1;
    es = reset && id_valid && !flush && pipe[0].v && pipe[0].ld && pipe[0].rd != XZR &&
         ((id_use_rn && int'(id_rn) == pipe[0].rd) || (id_use_rm && int'(id_rm) == pipe[0].rd));
    check_val("stall", int'(stall), int'(es));
    na = exp_sel(id_use_rn, int'(id_rn));
    nb = exp_sel(id_use_rm, int'(id_rm));
    @(posedge clk);
    if (!reset) begin
      pipe[0].v = 1'b0; pipe[1].v = 1'b0; m_a = 0; m_b = 0; m_cnt = 0;
    end else if (flush) begin
      pipe[0].v = 1'b0; pipe[1].v = 1'b0; m_a = 0; m_b = 0;
    end else if (hold) begin
      m_cnt = m_cnt;
    end else if (es) begin
      pipe[1] = pipe[0]; pipe[0].v = 1'b0; m_a = 0; m_b = 0;
      if (m_cnt < CMAX) m_cnt++;
    end else begin
      pipe[1] = pipe[0];
      pipe[0] = '{v: id_valid, rd: int'(id_rd), wr: id_reg_write, ld: id_mem_read};
      m_a = na; m_b = nb;
    end
    #1;
    check_val("fwd_a_sel", int'(fwd_a_sel), m_a);
    check_val("fwd_b_sel", int'(fwd_b_sel), m_b);
    check_val("stall_count", int'(stall_count), m_cnt);
  endtask

  task automatic ins(input bit v, input int rn, input bit urn, input int rm, input bit urm,
                     input int rd, input bit wr, input bit ld);
    id_valid = v; id_rn = rn[4:0]; id_use_rn = urn; id_rm = rm[4:0]; id_use_rm = urm;
    id_rd = rd[4:0]; id_reg_write = wr; id_mem_read = ld;
    cycle();
  endtask

  function automatic int rreg();
    int r;
    r = int'($urandom_range(0, 4));
    return (r == 4) ? XZR : r;
  endfunction

  initial begin
    pipe[0] = '{v: 1'b0, rd: 0, wr: 1'b0, ld: 1'b0};
    pipe[1] = pipe[0];
    m_a = 0; m_b = 0; m_cnt = 0;
    hold = 1'b0; flush = 1'b0; reset = 1'b0;
    ins(1'b1, 5, 1'b1, 5, 1'b1, 5, 1'b1, 1'b1);
    ins(1'b1, 5, 1'b1, 5, 1'b1, 5, 1'b1, 1'b1);
    reset = 1'b1;
    ins(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    // ADD X3 then SUB X4,X3,X3 then a reader of X3 two behind
    ins(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0);
    ins(1'b1, 3, 1'b1, 3, 1'b1, 4, 1'b1, 1'b0);
    ins(1'b1, 0, 1'b1, 3, 1'b1, 6, 1'b1, 1'b0);
    ins(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
    // X3 written in both EX and MEM, then XZR writers and XZR reader
    ins(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0);
    ins(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0);
    ins(1'b1, 3, 1'b1, 0, 1'b0, 7, 1'b1, 1'b0);
    ins(1'b1, 1, 1'b1, 2, 1'b1, XZR, 1'b1, 1'b1);
    ins(1'b1, 1, 1'b1, 2, 1'b1, XZR, 1'b1, 1'b0);
    ins(1'b1, XZR, 1'b1, XZR, 1'b1, 8, 1'b1, 1'b0);
    // LDUR X5, ADD rn=5 -> one bubble then MEM/WB forward
    ins(1'b1, 1, 1'b1, 2, 1'b1, 5, 1'b1, 1'b1);
    ins(1'b1, 5, 1'b1, 2, 1'b1, 9, 1'b1, 1'b0);
    ins(1'b1, 5, 1'b1, 2, 1'b1, 9, 1'b1, 1'b0);
    // Flush against a pending load-use
    ins(1'b1, 1, 1'b1, 2, 1'b1, 5, 1'b1, 1'b1);
    flush = 1'b1;
    ins(1'b1, 5, 1'b1, 2, 1'b1, 9, 1'b1, 1'b0);
    flush = 1'b0;
    ins(1'b1, 5, 1'b1, 2, 1'b1, 9, 1'b1, 1'b0);
    // Hold against a pending load-use (rm side)
    ins(1'b1, 1, 1'b1, 2, 1'b1, 5, 1'b1, 1'b1);
    hold = 1'b1;
    ins(1'b1, 1, 1'b1, 5, 1'b1, 9, 1'b1, 1'b0);
    ins(1'b1, 1, 1'b1, 5, 1'b1, 9, 1'b1, 1'b0);
    hold = 1'b0;
    ins(1'b1, 1, 1'b1, 5, 1'b1, 9, 1'b1, 1'b0);
    ins(1'b1, 1, 1'b1, 5, 1'b1, 9, 1'b1, 1'b0);
    // Reset asserted on a hazard cycle discards the pipeline
    ins(1'b1, 1, 1'b1, 2, 1'b1, 5, 1'b1, 1'b1);
    reset = 1'b0;
    ins(1'b1, 5, 1'b1, 2, 1'b1, 9, 1'b1, 1'b0);
    reset = 1'b1;
    ins(1'b1, 5, 1'b1, 9, 1'b1, 9, 1'b1, 1'b0);
    // Drive the counter past saturation
    for (int i = 0; i < CMAX + 3; i++) begin
      ins(1'b1, 1, 1'b1, 2, 1'b1, 5, 1'b1, 1'b1);
      ins(1'b1, 5, 1'b1, 5, 1'b1, 9, 1'b1, 1'b0);
    end
    check_val("sat", int'(stall_count), CMAX);
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      hold  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 63) != 0);
      ins(($urandom_range(0, 5) != 0), rreg(), $urandom_range(0, 1) == 1, rreg(),
          $urandom_range(0, 1) == 1, rreg(), $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/forward_ctrl.md
Name: forward_ctrl

Overview:
- Forwarding and load-use hazard controller for the 64-bit pipelined ARM datapath.
- Tracks the destination registers of the instructions in EX and MEM using internal shadow pipeline registers.
- Produces registered 2-bit select codes that drive the two EX-stage operand muxes (mux64_4, sel input) for operands A and B.
- Raises a combinational stall request on a load-use hazard and counts those stalls.

Parameters:
REG_W, 5, register index width
ZERO_REG, 31, index of XZR; never a forwarding source, always reads zero
CNT_W, 16, width of the load-use stall counter

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-low; state clears on a posedge where reset==0
id_valid  input  1  ID stage holds a real instruction
id_rn  input  REG_W  ID source register A
id_rm  input  REG_W  ID source register B
id_use_rn  input  1  instruction reads rn
id_use_rm  input  1  instruction reads rm
id_rd  input  REG_W  ID destination register
id_reg_write  input  1  instruction writes rd
id_mem_read  input  1  instruction is a load (LDUR)
hold  input  1  global freeze (external memory wait)
flush  input  1  branch taken; squash the ID and EX instructions
fwd_a_sel  output  2  operand-A mux select, valid while the instruction is in EX
fwd_b_sel  output  2  operand-B mux select, valid while the instruction is in EX
stall  output  1  load-use stall request (combinational); upstream holds PC and IF/ID
stall_count  output  CNT_W  saturating count of load-use stall cycles

Behaviour:
- State:
  - ex_q = {valid, rd, reg_write, mem_read} for the instruction now in EX.
  - mem_q = {valid, rd, reg_write} for the instruction now in MEM.
  - Registered fwd_a_sel/fwd_b_sel.
  - stall_count.
- Reset (reset==0 at posedge):
  - ex_q.valid and mem_q.valid = 0.
  - fwd_*_sel = 2'b00.
  - stall_count = 0.
  - stall is forced 0 while reset==0.
- Select encoding:
  - 00 = register file.
  - 01 = EX/MEM ALU result.
  - 10 = MEM/WB result.
  - 11 = constant zero.
- Per-operand select, computed combinationally in ID and registered at posedge (1-cycle latency, aligned with EX):
  - If the operand is not used, or id_valid==0: 00.
  - Else if src==ZERO_REG: 11.
  - Else if ex_q.valid && ex_q.reg_write && ex_q.rd==src && ex_q.rd!=ZERO_REG: 01. The EX producer has priority over the MEM producer.
  - Else if mem_q.valid && mem_q.reg_write && mem_q.rd==src && mem_q.rd!=ZERO_REG: 10.
  - Else 00.
- Load-use stall (combinational):
  - stall = reset && id_valid && !flush && ex_q.valid && ex_q.mem_read && ex_q.rd!=ZERO_REG && ((id_use_rn && id_rn==ex_q.rd) || (id_use_rm && id_rm==ex_q.rd)).
- Update at posedge when reset==1, in priority order:
  - flush: ex_q.valid <= 0, mem_q.valid <= 0, fwd sels <= 00. flush overrides hold and stall.
  - hold (no flush): all state holds and stall_count does not increment. stall still evaluates combinationally.
  - stall: a bubble is inserted. ex_q.valid <= 0, mem_q <= ex_q, fwd sels <= 00, stall_count increments and saturates at all-ones.
  - normal: ex_q <= ID fields with valid=id_valid, mem_q <= ex_q, fwd sels <= computed values.
- After a 1-cycle stall the load sits in MEM, so the held ID instruction resolves to select 10. A single load-use hazard never stalls more than one cycle.
- Reset mid-stall: the bubble and all shadow state are discarded, and the next cycle after reset release sees an empty pipeline.

Decomposition:
- Shared package fwd_pkg:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_ZERO=2'b11.
  - ZERO_REG constant.
  - ex_info_t and mem_info_t structs.
- Sub-module fwd_operand_sel:
  - Takes src, use, ex_q and mem_q; returns fwd_sel_t and a load-hit bit.
  - Instantiated once for rn and once for rm.

Test Plan:
- Reset=0 for 2 cycles, then release with id_valid=0 -> fwd_a_sel=fwd_b_sel=00, stall=0, stall_count=0.
- ADD X3 (rd=3, reg_write) followed by SUB using rn=3, rm=3 -> next cycle fwd_a_sel=fwd_b_sel=01. An instruction two behind with rm=3 -> fwd_b_sel=10.
- X3 written by both the EX and MEM instructions, ID reads rn=3 -> fwd_a_sel=01 (EX priority). rn=31 with rd=31 writers ahead -> fwd_a_sel=11, no stall.
- LDUR X5 followed by ADD rn=5 -> stall=1 for exactly one cycle, stall_count 0->1, bubble (sels 00). The next cycle gives fwd_a_sel=10 and stall=0.
- LDUR X5 in EX and ADD rn=5 in ID with flush=1 -> stall=0, sels 00, both shadows invalid, stall_count unchanged. With hold=1 instead of flush -> stall=1 but the count and state are frozen.
- Force stall_count to all-ones via 65535 load-use hazards, then one more hazard -> stall_count stays at 16'hFFFF.
